dmem_responder: RTL and testbench

//  Multi-cycle data-memory responder: the memory-side end of the core's load/store port.

---
 rtl/core_pkg.sv | 27 ++
 rtl/lsu_align.sv | 50 +++++
 rtl/dmem_responder.sv | 109 ++++++++++
 tb/tb_dmem_responder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core constants: RV32I load/store funct3 encodings, opcodes and the
// data-memory responder state encoding and request record.
package core_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } rsp_state_e;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct3;
    } mem_req_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for RV32I loads/stores: builds the store byte mask and
// replicated write word, and extracts/extends the load value from a read word.
module lsu_align
    import core_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wmask,
    output logic [31:0] wword,
    output logic [31:0] ldata
);

    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        wmask = 4'b0000;
        wword = 32'h0;
        ldata = 32'h0;
        bsel  = rword[8*lane +: 8];
        hsel  = lane[1] ? rword[31:16] : rword[15:0];

        // Write data is replicated across lanes so the mask alone picks the target bytes.
        case (funct3[1:0])
            2'b00: begin
                wmask = 4'b0001 << lane;
                wword = {4{wdata[7:0]}};
            end
            2'b01: begin
                wmask = lane[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
            end
            default: begin
                wmask = 4'b1111;
                wword = wdata;
            end
        endcase

        case (funct3)
            F3_B:    ldata = {{24{bsel[7]}}, bsel};
            F3_BU:   ldata = {24'h0, bsel};
            F3_H:    ldata = {{16{hsel[15]}}, hsel};
            F3_HU:   ldata = {16'h0, hsel};
            default: ldata = rword;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store at a time,
// fixed latency, misaligned / out-of-range / illegal-funct3 faults.
module dmem_responder
    import core_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    rsp_state_e  state, state_nx;
    logic [3:0]  count;
    mem_req_t    cap, in_req, ev;
    logic [31:0] mem [DEPTH_WORDS];

    logic          eval, ev_err, f3_bad, mis_al, oor;
    logic [AW-1:0] idx;
    logic [31:0]   rword, wword, ldata;
    logic [3:0]    wmask;

    assign in_req    = '{write: req_write, addr: req_addr, wdata: req_wdata, funct3: req_funct3};
    assign req_ready = (state == ST_IDLE);

    // With LATENCY=1 the request is evaluated on its acceptance edge, straight from the ports.
    assign ev   = (state == ST_IDLE) ? in_req : cap;
    assign eval = (state == ST_IDLE && req_valid && LATENCY == 1) ||
                  (state == ST_WAIT && count == 4'd1);

    assign idx   = ev.addr[AW+1:2];
    assign rword = mem[idx];

    always_comb begin
        if (ev.write)
            f3_bad = ev.funct3[2] || (ev.funct3[1:0] == 2'b11);
        else
            f3_bad = (ev.funct3 == 3'b011) || (ev.funct3[2:1] == 2'b11);
        mis_al = (ev.funct3[1:0] == 2'b01 && ev.addr[0]) ||
                 (ev.funct3[1:0] == 2'b10 && ev.addr[1:0] != 2'b00);
        oor    = (ev.addr >> (AW + 2)) != 32'h0;
        ev_err = f3_bad || mis_al || oor;
    end

    lsu_align u_align (
        .lane   (ev.addr[1:0]),
        .funct3 (ev.funct3),
        .wdata  (ev.wdata),
        .rword  (rword),
        .wmask  (wmask),
        .wword  (wword),
        .ldata  (ldata)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (req_valid) state_nx = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (count == 4'd1) state_nx = ST_RESP;
            ST_RESP: if (resp_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            count      <= 4'd0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && req_valid) begin
                cap   <= in_req;
                count <= 4'(LATENCY - 1);
            end else if (state == ST_WAIT) begin
                count <= count - 4'd1;
            end
            if (eval) begin
                resp_valid <= 1'b1;
                resp_err   <= ev_err;
                resp_rdata <= (ev_err || ev.write) ? 32'h0 : ldata;
            end else if (state == ST_RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

    // Storage is never cleared; faulted stores and stores dropped by reset leave it untouched.
    always_ff @(posedge clk) begin
        if (!rst && eval && ev.write && !ev_err)
            for (int i = 0; i < 4; i++)
                if (wmask[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: lane steering, extension, faults,
// response back-pressure and reset while a store is in flight.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a request; return just after the accepting edge with the port scrambled.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f3);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_funct3 = f3;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = ~w; req_addr = 32'hFFFF_FFFF;
        req_wdata = 32'h5A5A_5A5A; req_funct3 = 3'b111;
    endtask

    // Count edges from acceptance until resp_valid is seen; bounded.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_resp(input string tag);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({tag, "/idle_rdy"}, {31'h0, req_ready}, 32'h1);
        chk({tag, "/idle_vld"}, {31'h0, resp_valid}, 32'h0);
    endtask

    task automatic txn(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f3,
                       input logic [31:0] exp_data, input logic exp_err);
        int lat;
        issue(w, a, d, f3);
        chk({tag, "/busy"}, {31'h0, req_ready}, 32'h0);
        wait_resp(lat);
        chk({tag, "/lat"}, lat, LAT);
        chk({tag, "/rdata"}, resp_rdata, exp_data);
        chk({tag, "/err"}, {31'h0, resp_err}, {31'h0, exp_err});
        release_resp(tag);
    endtask

    initial begin
        int lat;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_funct3 = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst/resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst/resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst/resp_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        txn("sw10", 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0);
        txn("lw10", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0);

        txn("sw20", 1'b1, 32'h20, 32'h80FF_7F01, 3'b010, 32'h0, 1'b0);
        txn("lb23", 1'b0, 32'h23, 32'h0, 3'b000, 32'hFFFF_FF80, 1'b0);
        txn("lbu23", 1'b0, 32'h23, 32'h0, 3'b100, 32'h0000_0080, 1'b0);
        txn("lh22", 1'b0, 32'h22, 32'h0, 3'b001, 32'hFFFF_80FF, 1'b0);
        txn("lhu20", 1'b0, 32'h20, 32'h0, 3'b101, 32'h0000_7F01, 1'b0);

        txn("sw20b", 1'b1, 32'h20, 32'h1122_3344, 3'b010, 32'h0, 1'b0);
        txn("sb21", 1'b1, 32'h21, 32'h0000_00AB, 3'b000, 32'h0, 1'b0);
        txn("lw20a", 1'b0, 32'h20, 32'h0, 3'b010, 32'h1122_AB44, 1'b0);
        txn("sh22", 1'b1, 32'h22, 32'h0000_CDEF, 3'b001, 32'h0, 1'b0);
        txn("lw20b", 1'b0, 32'h20, 32'h0, 3'b010, 32'hCDEF_AB44, 1'b0);

        txn("e_lw12", 1'b0, 32'h12, 32'h0, 3'b010, 32'h0, 1'b1);
        txn("e_sh13", 1'b1, 32'h13, 32'hFFFF_FFFF, 3'b001, 32'h0, 1'b1);
        txn("e_oor", 1'b0, 32'(4 * DEPTH), 32'h0, 3'b010, 32'h0, 1'b1);
        txn("e_sf100", 1'b1, 32'h10, 32'h0, 3'b100, 32'h0, 1'b1);
        txn("e_lf011", 1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1);
        txn("lw10u", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0);
        txn("lw20u", 1'b0, 32'h20, 32'h0, 3'b010, 32'hCDEF_AB44, 1'b0);

        // Back-pressure: hold response for 5 cycles with a competing request on the port.
        issue(1'b0, 32'h20, 32'h0, 3'b010);
        wait_resp(lat);
        chk("stall/lat", lat, LAT);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
        req_wdata = 32'h0; req_funct3 = 3'b010;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall/vld", {31'h0, resp_valid}, 32'h1);
            chk("stall/rdata", resp_rdata, 32'hCDEF_AB44);
            chk("stall/rdy", {31'h0, req_ready}, 32'h0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        release_resp("stall");
        txn("lw20s", 1'b0, 32'h20, 32'h0, 3'b010, 32'hCDEF_AB44, 1'b0);

        // Reset while a store waits: it must be dropped.
        issue(1'b1, 32'h10, 32'h5555_5555, 3'b010);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstw/vld", {31'h0, resp_valid}, 32'h0);
        chk("rstw/rdy", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        txn("lw10r", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
